dual_bus_capture_align: RTL and testbench

//  Front-end stage of the redundant-bus comparison path. Captures write/read beats from the two

---
 rtl/dual_bus_capture_align.sv | 149 ++++++++++++++
 tb/tb_dual_bus_capture_align.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dual_bus_capture_align.sv
// Redundant-bus front end: captures A/B beats into per-channel FIFOs, pairs them in
// arrival order for the comparator, and flags channel skew and FIFO overflow.
module dual_bus_capture_align #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int SKEW_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_a_valid,
  input  logic             i_a_wr,
  input  logic [AW-1:0]    i_a_addr,
  input  logic [DW-1:0]    i_a_data,
  input  logic             i_b_valid,
  input  logic             i_b_wr,
  input  logic [AW-1:0]    i_b_addr,
  input  logic [DW-1:0]    i_b_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [AW+DW:0]   o_out_a,
  output logic [AW+DW:0]   o_out_b,
  output logic             o_skew_err,
  output logic [1:0]       o_ovf_err,
  input  logic             i_err_clr
);

  localparam int PW    = 1 + AW + DW;
  localparam int PTRW  = $clog2(DEPTH);
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int SKW   = $clog2(SKEW_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_B, S_WAIT_A, S_FAULT} state_t;

  state_t            r_state;
  logic [SKW-1:0]    r_skew_cnt;
  logic              r_skew_err;
  logic [1:0]        r_ovf_err;

  logic [PW-1:0]     r_mem   [2][DEPTH];
  logic [PTRW-1:0]   r_wptr  [2];
  logic [PTRW-1:0]   r_rptr  [2];
  logic [CNTW-1:0]   r_cnt   [2];

  logic [PW-1:0]     w_beat  [2];
  logic [1:0]        w_push;
  logic [1:0]        w_nempty;
  logic [1:0]        w_full;
  logic [1:0]        w_accept;
  logic [1:0]        w_ovf_evt;
  logic              w_pop;
  logic              w_block;
  logic              w_unbal_a;
  logic              w_unbal_b;
  logic              w_fault_enter;
  logic [SKW-1:0]    w_skew_inc;

  assign w_beat[0] = {i_a_wr, i_a_addr, i_a_data};
  assign w_beat[1] = {i_b_wr, i_b_addr, i_b_data};
  assign w_push    = {i_b_valid, i_a_valid};

  // Skew is judged on what is visible at the FIFO heads this cycle.
  assign w_unbal_b     = w_nempty[0] & ~w_nempty[1];
  assign w_unbal_a     = ~w_nempty[0] & w_nempty[1];
  assign w_skew_inc    = (r_skew_cnt >= SKW'(SKEW_MAX)) ? SKW'(SKEW_MAX) : r_skew_cnt + 1'b1;
  assign w_fault_enter = ((r_state == S_WAIT_B && w_unbal_b) || (r_state == S_WAIT_A && w_unbal_a))
                         && (w_skew_inc == SKW'(SKEW_MAX));
  assign w_block       = (r_state == S_FAULT) || w_fault_enter;

  assign o_out_valid = w_nempty[0] & w_nempty[1] & (r_state != S_FAULT);
  assign w_pop       = o_out_valid & i_out_ready;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_nempty[c]  = (r_cnt[c] != '0);
      w_full[c]    = (r_cnt[c] == CNTW'(DEPTH));
      w_accept[c]  = w_push[c] & ~w_block & (~w_full[c] | w_pop);
      w_ovf_evt[c] = w_push[c] & ~w_block & w_full[c] & ~w_pop;
    end
  end

  assign o_out_a    = w_nempty[0] ? r_mem[0][r_rptr[0]] : '0;
  assign o_out_b    = w_nempty[1] ? r_mem[1][r_rptr[1]] : '0;
  assign o_skew_err = r_skew_err;
  assign o_ovf_err  = r_ovf_err;

  // Storage is left unreset; stale entries are masked by the occupancy counts.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (w_accept[c]) r_mem[c][r_wptr[c]] <= w_beat[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst || w_fault_enter) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end else begin
        if (w_accept[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_pop)       r_rptr[c] <= r_rptr[c] + 1'b1;
        case ({w_accept[c], w_pop})
          2'b10:   r_cnt[c] <= r_cnt[c] + 1'b1;
          2'b01:   r_cnt[c] <= r_cnt[c] - 1'b1;
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
    end
  end

  // Fault entry beats a simultaneous err_clr; a new overflow beats err_clr too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_skew_cnt <= '0;
      r_skew_err <= 1'b0;
      r_ovf_err  <= 2'b00;
    end else begin
      case (r_state)
        S_FAULT: begin
          if (i_err_clr) begin
            r_state    <= S_IDLE;
            r_skew_cnt <= '0;
          end
        end
        default: begin
          if (w_fault_enter) begin
            r_state    <= S_FAULT;
            r_skew_cnt <= w_skew_inc;
          end else if (w_unbal_b) begin
            r_state    <= S_WAIT_B;
            r_skew_cnt <= (r_state == S_WAIT_B) ? w_skew_inc : SKW'(1);
          end else if (w_unbal_a) begin
            r_state    <= S_WAIT_A;
            r_skew_cnt <= (r_state == S_WAIT_A) ? w_skew_inc : SKW'(1);
          end else begin
            r_state    <= S_IDLE;
            r_skew_cnt <= '0;
          end
        end
      endcase
      if (w_fault_enter)  r_skew_err <= 1'b1;
      else if (i_err_clr) r_skew_err <= 1'b0;
      r_ovf_err <= (r_ovf_err & ~{2{i_err_clr}}) | w_ovf_evt;
    end
  end

endmodule

// File: tb/tb_dual_bus_capture_align.sv
// Directed self-checking bench for dual_bus_capture_align: alignment, tolerated skew,
// skew fault and recovery, overflow, reset mid-operation, full FIFO with pop.
module tb_dual_bus_capture_align;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int PW = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          aValid, aWr, bValid, bWr;
  logic [AW-1:0] aAddr, bAddr;
  logic [DW-1:0] aData, bData;
  logic          outValid, outReady, skewErr, errClr;
  logic [PW-1:0] outA, outB;
  logic [1:0]    ovfErr;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [PW-1:0] NONE = '0;
  localparam logic [PW-1:0] T1BEAT = {1'b1, 16'h0010, 32'hDEADBEEF};

  dual_bus_capture_align #(.AW(AW), .DW(DW), .DEPTH(4), .SKEW_MAX(15)) dut (
    .clk(clk), .rst(rst),
    .i_a_valid(aValid), .i_a_wr(aWr), .i_a_addr(aAddr), .i_a_data(aData),
    .i_b_valid(bValid), .i_b_wr(bWr), .i_b_addr(bAddr), .i_b_data(bData),
    .o_out_valid(outValid), .i_out_ready(outReady),
    .o_out_a(outA), .o_out_b(outB),
    .o_skew_err(skewErr), .o_ovf_err(ovfErr), .i_err_clr(errClr)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] beatA(input int i);
    return {1'b1, 16'(i), 32'(i)};
  endfunction

  function automatic logic [PW-1:0] beatB(input int i);
    return {1'b0, 16'h8000 | 16'(i), 32'hB000_0000 | 32'(i)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, clocks one edge, returns 1 time unit after it.
  task automatic applyStimulus(input logic av, input logic [PW-1:0] ab,
                               input logic bv, input logic [PW-1:0] bb,
                               input logic ready, input logic clr, input logic rstIn);
    aValid = av; {aWr, aAddr, aData} = ab;
    bValid = bv; {bWr, bAddr, bData} = bb;
    outReady = ready; errClr = clr; rst = rstIn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ready);
    for (int k = 0; k < n; k++) applyStimulus(0, NONE, 0, NONE, ready, 0, 0);
  endtask

  initial begin
    applyStimulus(0, NONE, 0, NONE, 0, 0, 1);
    applyStimulus(0, NONE, 0, NONE, 0, 0, 1);
    checkOutput("rst_valid", 64'(outValid), 64'd0);
    checkOutput("rst_skew", 64'(skewErr), 64'd0);
    checkOutput("rst_ovf", 64'(ovfErr), 64'd0);
    checkOutput("rst_outa", 64'(outA), 64'd0);
    checkOutput("rst_outb", 64'(outB), 64'd0);

    $display("[TB] aligned pair");
    applyStimulus(1, T1BEAT, 1, T1BEAT, 1, 0, 0);
    checkOutput("t1_valid", 64'(outValid), 64'd1);
    checkOutput("t1_outa", 64'(outA), 64'(T1BEAT));
    checkOutput("t1_outb", 64'(outB), 64'(T1BEAT));
    idle(1, 1);
    checkOutput("t1_popped", 64'(outValid), 64'd0);
    checkOutput("t1_outa_empty", 64'(outA), 64'd0);

    $display("[TB] tolerated skew");
    applyStimulus(1, beatA(32), 0, NONE, 1, 0, 0);
    idle(4, 1);
    checkOutput("t2_wait", 64'(outValid), 64'd0);
    checkOutput("t2_outa_head", 64'(outA), 64'(beatA(32)));
    applyStimulus(0, NONE, 1, beatB(32), 1, 0, 0);
    checkOutput("t2_valid", 64'(outValid), 64'd1);
    checkOutput("t2_outb", 64'(outB), 64'(beatB(32)));
    checkOutput("t2_skew", 64'(skewErr), 64'd0);
    idle(1, 1);
    checkOutput("t2_popped", 64'(outValid), 64'd0);

    $display("[TB] skew fault");
    applyStimulus(1, beatA(48), 0, NONE, 1, 0, 0);
    idle(14, 1);
    checkOutput("t3_skew_before", 64'(skewErr), 64'd0);
    checkOutput("t3_outa_held", 64'(outA), 64'(beatA(48)));
    idle(1, 1);
    checkOutput("t3_skew_set", 64'(skewErr), 64'd1);
    checkOutput("t3_valid", 64'(outValid), 64'd0);
    checkOutput("t3_flushed", 64'(outA), 64'd0);
    applyStimulus(1, beatA(49), 1, beatB(49), 1, 0, 0);
    checkOutput("t3_push_ignored_a", 64'(outA), 64'd0);
    checkOutput("t3_push_ignored_b", 64'(outB), 64'd0);
    checkOutput("t3_fault_valid", 64'(outValid), 64'd0);
    checkOutput("t3_fault_ovf", 64'(ovfErr), 64'd0);
    applyStimulus(0, NONE, 0, NONE, 1, 1, 0);
    checkOutput("t3_clr", 64'(skewErr), 64'd0);
    applyStimulus(1, beatA(50), 1, beatB(50), 1, 0, 0);
    checkOutput("t3_recover_valid", 64'(outValid), 64'd1);
    checkOutput("t3_recover_outa", 64'(outA), 64'(beatA(50)));
    idle(1, 1);
    checkOutput("t3_recover_pop", 64'(outValid), 64'd0);

    $display("[TB] overflow");
    for (int i = 1; i <= 4; i++) applyStimulus(1, beatA(i), 1, beatB(i), 0, 0, 0);
    checkOutput("t4_full_no_ovf", 64'(ovfErr), 64'd0);
    applyStimulus(1, beatA(5), 1, beatB(5), 0, 0, 0);
    checkOutput("t4_ovf", 64'(ovfErr), 64'd3);
    checkOutput("t4_head_stable", 64'(outA), 64'(beatA(1)));
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("t4_valid%0d", i), 64'(outValid), 64'd1);
      checkOutput($sformatf("t4_outa%0d", i), 64'(outA), 64'(beatA(i)));
      checkOutput($sformatf("t4_outb%0d", i), 64'(outB), 64'(beatB(i)));
      idle(1, 1);
    end
    checkOutput("t4_drained", 64'(outValid), 64'd0);
    checkOutput("t4_ovf_sticky", 64'(ovfErr), 64'd3);

    $display("[TB] reset mid-operation");
    applyStimulus(1, beatA(7), 1, beatB(7), 0, 0, 0);
    applyStimulus(1, beatA(8), 1, beatB(8), 0, 0, 0);
    checkOutput("t6_queued", 64'(outValid), 64'd1);
    applyStimulus(0, NONE, 0, NONE, 0, 0, 1);
    checkOutput("t6_valid", 64'(outValid), 64'd0);
    checkOutput("t6_ovf", 64'(ovfErr), 64'd0);
    checkOutput("t6_skew", 64'(skewErr), 64'd0);
    checkOutput("t6_outa", 64'(outA), 64'd0);
    idle(1, 1);
    checkOutput("t6_no_stale", 64'(outValid), 64'd0);
    checkOutput("t6_outb", 64'(outB), 64'd0);

    $display("[TB] full with pop");
    for (int i = 1; i <= 4; i++) applyStimulus(1, beatA(i), 1, beatB(i), 0, 0, 0);
    checkOutput("t5_full_head", 64'(outA), 64'(beatA(1)));
    applyStimulus(1, beatA(9), 1, beatB(9), 1, 0, 0);
    checkOutput("t5_no_ovf", 64'(ovfErr), 64'd0);
    begin
      int order [4] = '{2, 3, 4, 9};
      for (int j = 0; j < 4; j++) begin
        checkOutput($sformatf("t5_outa%0d", j), 64'(outA), 64'(beatA(order[j])));
        checkOutput($sformatf("t5_outb%0d", j), 64'(outB), 64'(beatB(order[j])));
        idle(1, 1);
      end
    end
    checkOutput("t5_drained", 64'(outValid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
